div3_sched: RTL



---
 rtl/div3_sched_pkg.sv | 22 ++
 rtl/div3.sv | 11 +
 rtl/div3_sched_rr_arbiter.sv | 52 +++++
 rtl/div3_sched.sv | 97 +++++++++
 4 files changed

// File: rtl/div3_sched_pkg.sv
// Shared widths, defaults and reset values for the div3 scheduler slice,
// plus the multiply-shift divide-by-3 used by the shared arithmetic unit.
package div3_sched_pkg;

    localparam int DATA_W   = 8;
    localparam int NREQ_DEF = 4;
    localparam int ID_W_DEF = 2;

    localparam logic [DATA_W-1:0] RST_RESULT = '0;
    localparam logic              RST_VALID  = 1'b0;

    // 21849 / 65536 is just above 1/3; the error stays below one LSB across 0..255.
    localparam logic [15:0] DIV3_MAGIC = 16'd21849;
    localparam int          DIV3_SHIFT = 16;

    function automatic logic [DATA_W-1:0] div3_mul(input logic [DATA_W-1:0] x);
        logic [DATA_W+15:0] prod;
        prod = {16'b0, x} * {{DATA_W{1'b0}}, DIV3_MAGIC};
        return prod[DATA_W+DIV3_SHIFT-1:DIV3_SHIFT];
    endfunction

endpackage

// File: rtl/div3.sv
// Existing combinational 8-bit unsigned divide-by-3: q = floor(x / 3), range 0..85.
module div3
    import div3_sched_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_q
);

    assign o_q = div3_mul(i_x);

endmodule

// File: rtl/div3_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester at or
// after i_ptr, wrapping to index 0, and returns it one-hot and encoded.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_elig;
    logic            w_hi_found;
    logic            w_lo_found;
    logic [ID_W-1:0] w_hi_idx;
    logic [ID_W-1:0] w_lo_idx;

    // Scan downward so the last hit is the lowest index in each half of the ring.
    always_comb begin
        w_elig     = i_req & ~i_mask;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_elig[j]) begin
                if (ID_W'(j) >= i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(j);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        o_any = w_hi_found | w_lo_found;
        o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        o_gnt = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (o_any && (o_idx == ID_W'(j))) begin
                o_gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div3_sched.sv
// Round-robin scheduler sharing one div3 unit between NREQ requesters:
// grant + operand capture in stage 1, registered quotient and id in stage 2.
module div3_sched
    import div3_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [DATA_W*NREQ-1:0] operand,
    output logic [NREQ-1:0]        gnt,
    output logic [DATA_W-1:0]      result,
    output logic                   result_valid,
    output logic [ID_W-1:0]        result_id
);

    logic [NREQ-1:0]   r_gnt_p1;
    logic [ID_W-1:0]   r_ptr;
    logic [DATA_W-1:0] r_opnd_p1;
    logic [ID_W-1:0]   r_id_p1;
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_result_p2;
    logic [ID_W-1:0]   r_id_p2;
    logic              r_vld_p2;

    logic [NREQ-1:0]   w_gnt;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [DATA_W-1:0] w_opnd;
    logic [DATA_W-1:0] w_quot;

    // Masking with last cycle's grant stops a held, already-served request from winning twice.
    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req  (req),
        .i_mask (r_gnt_p1),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_ptr_nxt = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);

    always_comb begin
        w_opnd = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt[j]) begin
                w_opnd = operand[DATA_W*j +: DATA_W];
            end
        end
    end

    div3 u_div3 (
        .i_x (r_opnd_p1),
        .o_q (w_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_p1    <= '0;
            r_ptr       <= '0;
            r_opnd_p1   <= '0;
            r_id_p1     <= '0;
            r_vld_p1    <= 1'b0;
            r_result_p2 <= RST_RESULT;
            r_id_p2     <= '0;
            r_vld_p2    <= RST_VALID;
        end else begin
            // Stage 1: arbitration, operand capture, pointer advance
            r_gnt_p1 <= w_gnt;
            r_vld_p1 <= w_any;
            if (w_any) begin
                r_opnd_p1 <= w_opnd;
                r_id_p1   <= w_idx;
                r_ptr     <= w_ptr_nxt;
            end
            // Stage 2: quotient and owner id; both hold between valid pulses
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_result_p2 <= w_quot;
                r_id_p2     <= r_id_p1;
            end
        end
    end

    assign gnt          = r_gnt_p1;
    assign result       = r_result_p2;
    assign result_valid = r_vld_p2;
    assign result_id    = r_id_p2;

endmodule
